// File: rtl/io_resp32.sv
// Bus-slave register block: 14 scratch regs, access counter, IRQ CSR.
// Fixed-latency acknowledge with abortable wait states.
module io_resp32 #(
  parameter logic [31:0] BASE_ADR    = 32'hFEE00000,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] adr_i,
  input  logic [31:0] dat_i,
  output logic        ack_o,
  output logic [31:0] dat_o,
  output logic        irq_o
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } state_e;

  localparam logic [3:0] WS_INIT =
    (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  state_e      state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic        irq_q, irq_d;
  logic [31:0] regs_q [14];
  logic [31:0] regs_d [14];
  logic [31:0] cnt_q, cnt_d;
  logic        ie_q, ie_d;
  logic        ip_q, ip_d;

  logic        cs;
  logic        bus_on;
  logic        commit;
  logic [3:0]  idx;
  logic [31:0] wmask;
  logic [31:0] rd_data;

  assign bus_on = cyc_i & stb_i;
  assign cs     = bus_on & (adr_i[31:6] == BASE_ADR[31:6]);
  assign idx    = adr_i[5:2];
  assign wmask  = {{8{sel_i[3]}}, {8{sel_i[2]}},
                   {8{sel_i[1]}}, {8{sel_i[0]}}};

  assign ack_o = ack_q;
  assign dat_o = dat_q;
  assign irq_o = irq_q;

  // Handshake FSM: commit pulses on the edge that enters ACK.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cs) begin
          if (WAIT_STATES == 0) begin
            state_d = ACK;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
            wcnt_d  = WS_INIT;
          end
        end
      end
      WAIT: begin
        if (!bus_on) begin
          state_d = IDLE;
          wcnt_d  = 4'd0;
        end else if (wcnt_q == 4'd0) begin
          state_d = ACK;
          commit  = 1'b1;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      ACK: begin
        if (!bus_on) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        wcnt_d  = 4'd0;
      end
    endcase
  end

  // Read mux; CNT reads see the pre-increment value.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < 14; i++) begin
      if (idx == 4'(i)) rd_data = regs_q[i];
    end
    if (idx == 4'd14) rd_data = cnt_q;
    if (idx == 4'd15) rd_data = {30'd0, ip_q, ie_q};
  end

  // Register file, counter, CSR and output next-values.
  always_comb begin
    regs_d = regs_q;
    cnt_d  = cnt_q;
    ie_d   = ie_q;
    ip_d   = ip_q;
    ack_d  = 1'b0;
    dat_d  = '0;
    if (state_d == ACK) begin
      ack_d = 1'b1;
      if (commit) dat_d = we_i ? 32'd0 : rd_data;
      else        dat_d = dat_q;
    end
    if (commit) begin
      cnt_d = cnt_q + 32'd1;
      if (we_i) begin
        for (int i = 0; i < 14; i++) begin
          if (idx == 4'(i))
            regs_d[i] = (regs_q[i] & ~wmask) | (dat_i & wmask);
        end
        if (idx == 4'd15 && sel_i[0]) begin
          ie_d = dat_i[0];
          if (dat_i[1]) ip_d = 1'b0;
        end
        // set after clear so a simultaneous set wins
        if (idx == 4'd0) ip_d = 1'b1;
      end
    end
    irq_d = ie_d & ip_d;
  end

  // All state, synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      wcnt_q  <= 4'd0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      irq_q   <= 1'b0;
      cnt_q   <= '0;
      ie_q    <= 1'b0;
      ip_q    <= 1'b0;
      for (int i = 0; i < 14; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      irq_q   <= irq_d;
      cnt_q   <= cnt_d;
      ie_q    <= ie_d;
      ip_q    <= ip_d;
      regs_q  <= regs_d;
    end
  end

endmodule

// File: tb/tb_io_resp32.sv
// Directed bench for io_resp32 with a read-data scoreboard.
// Expected values come from constants and a small access counter.
module tb_io_resp32;

  localparam int          WS   = 2;
  localparam logic [31:0] BASE = 32'hFEE00000;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        cyc_i, stb_i, we_i;
  logic [3:0]  sel_i;
  logic [31:0] adr_i, dat_i;
  logic        ack_o;
  logic [31:0] dat_o;
  logic        irq_o;

  int          pass_cnt = 0;
  int          fail_cnt = 0;
  int          total    = 0;
  logic [31:0] m_cnt    = 32'd0;
  logic [31:0] sb [$];

  io_resp32 #(
    .BASE_ADR   (BASE),
    .WAIT_STATES(WS)
  ) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .cyc_i (cyc_i),
    .stb_i (stb_i),
    .we_i  (we_i),
    .sel_i (sel_i),
    .adr_i (adr_i),
    .dat_i (dat_i),
    .ack_o (ack_o),
    .dat_o (dat_o),
    .irq_o (irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] adr_of(input logic [3:0] idx);
    return BASE | {26'd0, idx, 2'b00};
  endfunction

  task automatic bus_start(input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s);
    @(negedge clk_i);
    cyc_i = 1'b1;
    stb_i = 1'b1;
    we_i  = w;
    adr_i = a;
    dat_i = d;
    sel_i = s;
  endtask

  task automatic wait_ack(output int lat);
    lat = 0;
    do begin
      @(negedge clk_i);
      lat++;
    end while (!ack_o && lat < 20);
  endtask

  task automatic bus_end(input string tag);
    cyc_i = 1'b0;
    stb_i = 1'b0;
    we_i  = 1'b0;
    @(negedge clk_i);
    check({tag, "_ackdrop"}, 32'(ack_o), 32'd0);
    check({tag, "_datzero"}, dat_o, 32'd0);
  endtask

  task automatic wr(input logic [3:0] idx, input logic [31:0] d,
                    input logic [3:0] s, input string tag);
    int lat;
    bus_start(1'b1, adr_of(idx), d, s);
    wait_ack(lat);
    check({tag, "_lat"}, 32'(lat), 32'(WS + 1));
    m_cnt = m_cnt + 32'd1;
    bus_end(tag);
  endtask

  task automatic rd(input logic [3:0] idx, input logic [31:0] exp,
                    input string tag);
    int lat;
    logic [31:0] got;
    sb.push_back(exp);
    bus_start(1'b0, adr_of(idx), 32'd0, 4'hF);
    wait_ack(lat);
    check({tag, "_lat"}, 32'(lat), 32'(WS + 1));
    got = dat_o;
    check(tag, got, sb.pop_front());
    m_cnt = m_cnt + 32'd1;
    bus_end(tag);
  endtask

  initial begin
    int lat;
    rst_ni = 1'b0;
    cyc_i  = 1'b0;
    stb_i  = 1'b0;
    we_i   = 1'b0;
    sel_i  = 4'h0;
    adr_i  = 32'd0;
    dat_i  = 32'd0;
    repeat (2) @(negedge clk_i);
    check("rst_ack", 32'(ack_o), 32'd0);
    check("rst_dat", dat_o, 32'd0);
    check("rst_irq", 32'(irq_o), 32'd0);
    rst_ni = 1'b1;

    // write then read back, CNT pre-increment
    wr(4'd3, 32'hDEADBEEF, 4'hF, "wr3");
    rd(4'd3, 32'hDEADBEEF, "rd3");
    rd(4'd14, 32'd2, "cnt2");

    // byte lanes
    wr(4'd5, 32'h11223344, 4'b0101, "wr5");
    rd(4'd5, 32'h00220044, "rd5");

    // abort during wait
    bus_start(1'b1, adr_of(4'd3), 32'h12345678, 4'hF);
    @(negedge clk_i);
    cyc_i = 1'b0;
    stb_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      check("abort_noack", 32'(ack_o), 32'd0);
    end

    // non-matching address
    bus_start(1'b1, BASE | 32'h40, 32'hFFFFFFFF, 4'hF);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      check("miss_noack", 32'(ack_o), 32'd0);
    end
    cyc_i = 1'b0;
    stb_i = 1'b0;
    we_i  = 1'b0;

    rd(4'd3, 32'hDEADBEEF, "abort_rd3");
    rd(4'd14, m_cnt, "abort_cnt");

    // interrupt
    wr(4'd15, 32'd1, 4'hF, "ie_on");
    check("irq_ie_only", 32'(irq_o), 32'd0);
    wr(4'd0, 32'hA5, 4'hF, "set_ip");
    check("irq_set", 32'(irq_o), 32'd1);
    rd(4'd15, 32'd3, "csr3");
    wr(4'd15, 32'd2, 4'hF, "w1c");
    check("irq_clr", 32'(irq_o), 32'd0);
    rd(4'd15, 32'd0, "csr0");
    wr(4'd15, 32'd1, 4'hF, "ie_on2");
    wr(4'd0, 32'h5A, 4'hF, "set_ip2");
    wr(4'd0, 32'h5B, 4'hF, "set_ip3");
    check("irq_reset_set", 32'(irq_o), 32'd1);
    wr(4'd15, 32'd3, 4'hF, "w1c_ie");
    check("irq_clr2", 32'(irq_o), 32'd0);
    rd(4'd15, 32'd1, "csr1");

    // long strobe: one commit, held ack, no rewrite
    bus_start(1'b1, adr_of(4'd7), 32'hCAFEF00D, 4'hF);
    wait_ack(lat);
    check("long_lat", 32'(lat), 32'(WS + 1));
    m_cnt = m_cnt + 32'd1;
    dat_i = 32'h0BADBEEF;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      check("long_ack", 32'(ack_o), 32'd1);
    end
    bus_end("long");
    rd(4'd7, 32'hCAFEF00D, "long_rd7");
    rd(4'd14, m_cnt, "long_cnt");

    // long read keeps sampled data
    bus_start(1'b0, adr_of(4'd3), 32'd0, 4'hF);
    wait_ack(lat);
    m_cnt = m_cnt + 32'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("long_rd_dat", dat_o, 32'hDEADBEEF);
    end
    bus_end("long_rd");

    // reset while in ACK
    bus_start(1'b0, adr_of(4'd3), 32'd0, 4'hF);
    wait_ack(lat);
    check("rstack_dat", dat_o, 32'hDEADBEEF);
    rst_ni = 1'b0;
    @(negedge clk_i);
    check("rstack_ack", 32'(ack_o), 32'd0);
    check("rstack_dat0", dat_o, 32'd0);
    rst_ni = 1'b1;
    cyc_i  = 1'b0;
    stb_i  = 1'b0;
    m_cnt  = 32'd0;
    @(negedge clk_i);
    check("rstack_irq", 32'(irq_o), 32'd0);
    rd(4'd3, 32'd0, "rst_rd3");
    rd(4'd7, 32'd0, "rst_rd7");
    rd(4'd15, 32'd0, "rst_csr");
    rd(4'd14, m_cnt, "rst_cnt");

    // counter wrap
    @(negedge clk_i);
    force dut.cnt_q = 32'hFFFFFFFF;
    @(posedge clk_i);
    #1;
    release dut.cnt_q;
    m_cnt = 32'hFFFFFFFF;
    rd(4'd14, m_cnt, "wrap_pre");
    rd(4'd14, m_cnt, "wrap_zero");
    check("wrap_model", m_cnt, 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/io_resp32.md
IO_RESP32 -- requirements
Module: io_resp32

Interface
REQ-001 Parameters SHALL be (one per line: name, default, meaning):
- BASE_ADR, 32'hFEE00000, device base address; match on adr_i[31:6].
- WAIT_STATES, 2, extra cycles between select and ack; legal range 0..15.
REQ-002 Ports SHALL be (one per line: name, direction, width, meaning):
- clk_i  in  1  sole clock, all logic on rising edge.
- rst_ni  in  1  synchronous, active-low reset.
- cyc_i  in  1  bus cycle valid.
- stb_i  in  1  strobe.
- we_i  in  1  write enable.
- sel_i  in  4  byte lane selects.
- adr_i  in  32  byte address.
- dat_i  in  32  write data.
- ack_o  out  1  registered acknowledge.
- dat_o  out  32  read data.
- irq_o  out  1  interrupt request, level.
REQ-003 The block SHALL have exactly one clock, clk_i; rst_ni SHALL be synchronous and active-low.

Function
REQ-004 Select SHALL be cs = cyc_i & stb_i & (adr_i[31:6] == BASE_ADR[31:6]); register index SHALL be adr_i[5:2].
REQ-005 Register map:
- Index 0..13: 32-bit read/write scratch registers.
- Index 14: CNT, read-only, counts completed accesses, 32-bit, wraps FFFFFFFF->0.
- Index 15: CSR; bit0 IE (read/write); bit1 IP (write-1-to-clear); bits 31:2 read 0.
REQ-006 FSM states SHALL be IDLE, WAIT, ACK.
- IDLE: on cs, go to WAIT if WAIT_STATES>0 (load counter = WAIT_STATES-1), else to ACK.
- WAIT: decrement counter; go to ACK when the counter is 0.
- ACK: hold ack_o=1; return to IDLE in the cycle after stb_i or cyc_i is sampled low.
REQ-007 Latency: ack_o SHALL rise WAIT_STATES+1 cycles after the first cycle cs is sampled high.
REQ-008 In WAIT, if cyc_i or stb_i is sampled low, the FSM SHALL return to IDLE with no write, no CNT increment and no ack (abort).
REQ-009 Commit on the ACK-entry clock edge:
- Writes update only the byte lanes with sel_i set.
- Reads load dat_o with the selected register.
- CNT increments by 1.
REQ-010 Reads and writes to CNT and reserved CSR bits SHALL have no effect.
REQ-011 dat_o SHALL be 0 whenever ack_o is 0.
REQ-012 While in ACK, dat_o SHALL hold the sampled value and the register contents SHALL NOT be re-written, even if stb_i stays high.
REQ-013 A new access SHALL NOT be accepted until the FSM has returned to IDLE; back-to-back strobes SHALL be spaced by at least one IDLE cycle.
REQ-014 IP SHALL set on any write to index 0.
- If a set (write to index 0) and a W1C of IP occur in the same cycle, set SHALL win.
- irq_o SHALL equal IE & IP, registered.
REQ-015 A CNT read in the same access that increments CNT SHALL return the pre-increment value.
REQ-016 Non-matching addresses SHALL be ignored: no ack, no state change.

Reset
REQ-017 With rst_ni low at a clock edge, the block SHALL reset:
- FSM to IDLE, wait counter to 0.
- ack_o=0, dat_o=0, irq_o=0.
- Registers 0..13 to 0, CNT=0, IE=0, IP=0.
REQ-018 Reset asserted mid-access SHALL abort the access; ack_o SHALL be 0 in the following cycle regardless of stb_i.

Verification
REQ-019 Write then read, WAIT_STATES=2: write 32'hDEADBEEF, sel=F to index 3 -> ack_o rises 3 cycles after strobe. Then read index 3 -> dat_o=DEADBEEF during ack; CNT=2.
REQ-020 Byte lanes: index 5 holds 0. Write 32'h11223344 with sel=4'b0101 -> read returns 32'h00220044.
REQ-021 Abort: drop cyc_i during WAIT -> no ack, index unchanged, CNT unchanged, FSM in IDLE the next cycle.
REQ-022 Interrupt: write CSR=1 (IE), then write index 0 -> irq_o=1. Then write CSR=2 -> irq_o=0. Same-cycle set/clear case -> irq_o stays 1.
REQ-023 Long strobe: hold stb_i 10 cycles after ack -> ack_o high throughout, one CNT increment, then ack_o=0 and dat_o=0 in the cycle after stb_i falls.
REQ-024 Reset and wrap: pulse rst_ni low while in ACK -> next cycle ack_o=0 and all registers 0. Force CNT=FFFFFFFF, perform one access -> CNT=0.
